// File: rtl/duck_sprite_fetch.sv
// duck_sprite_fetch: per-pixel sprite address generator with a three-stage
// hit/index pipeline and a four-state wing-flap animation selector.
// Optional feature macro: SPRITE_MIRROR_EN adds the facing_left input, which
// mirrors the sprite horizontally.
module duck_sprite_fetch #(
    parameter int unsigned SPRITE_W    = 20,
    parameter int unsigned SPRITE_H    = 20,
    parameter int unsigned FLAP_DIV    = 8,
    parameter logic [4:0]  TRANSPARENT = 5'h00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pixel_valid,
    input  logic        frame_start,
    input  logic [9:0]  SpriteX,
    input  logic [9:0]  SpriteY,
`ifdef SPRITE_MIRROR_EN
    input  logic        facing_left,
`endif
    output logic [18:0] ram_addr,
    output logic [1:0]  frame_sel,
    input  logic [4:0]  ram_data,
    output logic        pix_valid_out,
    output logic        pix_hit,
    output logic [4:0]  pix_index
);

    localparam int unsigned XW = 10;   // screen coordinate width
    localparam int unsigned CW = 11;   // widened coordinate for box edges
    localparam int unsigned AW = 19;   // sprite RAM address width
    localparam int unsigned NW = 8;    // frame_start counter width

    typedef enum logic [1:0] {
        ANIM_UP    = 2'd0,
        ANIM_MID_A = 2'd1,
        ANIM_DOWN  = 2'd2,
        ANIM_MID_B = 2'd3
    } anim_state_t;

    // Latched sprite placement, valid for the whole frame
    logic [XW-1:0] pos_x;
    logic [XW-1:0] pos_y;

    // Animation state
    anim_state_t   anim_state;
    logic [NW-1:0] frame_cnt;

    // Pipeline qualifiers: stage 1 travels with ram_addr, stage 2 with ram_data
    logic          valid_s1;
    logic          box_s1;
    logic          valid_s2;
    logic          box_s2;

    // Combinational stage-0 signals
    logic [CW-1:0] x_ext_c;
    logic [CW-1:0] y_ext_c;
    logic [CW-1:0] x_lo_c;
    logic [CW-1:0] y_lo_c;
    logic [CW-1:0] x_hi_c;
    logic [CW-1:0] y_hi_c;
    logic          in_box_c;
    logic [XW-1:0] col_off_c;
    logic [XW-1:0] row_off_c;
    logic [AW-1:0] col_term_c;
    logic [AW-1:0] row_term_c;
    logic [AW-1:0] addr_c;
    logic          mirror_c;
    logic          hit_c;

`ifdef SPRITE_MIRROR_EN
    logic          facing_q;

    // Facing direction is sampled with the position so it stays frame-stable
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            facing_q <= 1'b0;
        end else if (frame_start) begin
            facing_q <= facing_left;
        end
    end

    assign mirror_c = facing_q;
`else
    assign mirror_c = 1'b0;
`endif

    // Sprite position loads only on frame_start; a coincident pixel still sees the old one
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (frame_start) begin
            pos_x <= SpriteX;
            pos_y <= SpriteY;
        end
    end

    // Box edges are widened by one bit so a sprite crossing 1023 never wraps to 0
    always_comb begin
        x_ext_c  = {1'b0, DrawX};
        y_ext_c  = {1'b0, DrawY};
        x_lo_c   = {1'b0, pos_x};
        y_lo_c   = {1'b0, pos_y};
        x_hi_c   = x_lo_c + CW'(SPRITE_W);
        y_hi_c   = y_lo_c + CW'(SPRITE_H);
        in_box_c = pixel_valid
                 && (x_ext_c >= x_lo_c) && (x_ext_c < x_hi_c)
                 && (y_ext_c >= y_lo_c) && (y_ext_c < y_hi_c);
    end

    // Linear sprite address; only meaningful when in_box_c is set
    always_comb begin
        col_off_c  = DrawX - pos_x;
        row_off_c  = DrawY - pos_y;
        row_term_c = AW'(row_off_c) * AW'(SPRITE_W);
        if (mirror_c) begin
            col_term_c = AW'(SPRITE_W - 1) - AW'(col_off_c);
        end else begin
            col_term_c = AW'(col_off_c);
        end
        addr_c = row_term_c + col_term_c;
    end

    // Stage 1: registered RAM address plus qualifiers for the request
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ram_addr <= '0;
            valid_s1 <= 1'b0;
            box_s1   <= 1'b0;
        end else begin
            ram_addr <= in_box_c ? addr_c : '0;
            valid_s1 <= pixel_valid;
            box_s1   <= in_box_c;
        end
    end

    // Stage 2: qualifiers wait while the RAM turns the address into data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_s2 <= 1'b0;
            box_s2   <= 1'b0;
        end else begin
            valid_s2 <= valid_s1;
            box_s2   <= box_s1;
        end
    end

    // Transparent texels inside the box are reported as background
    assign hit_c = box_s2 && (ram_data != TRANSPARENT);

    // Stage 3: registered pixel result
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_valid_out <= 1'b0;
            pix_hit       <= 1'b0;
            pix_index     <= '0;
        end else begin
            pix_valid_out <= valid_s2;
            pix_hit       <= hit_c;
            pix_index     <= hit_c ? ram_data : '0;
        end
    end

    // Wing-flap FSM: steps once every FLAP_DIV frame_start pulses, frame_sel registered
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            anim_state <= ANIM_UP;
            frame_cnt  <= '0;
            frame_sel  <= 2'd0;
        end else if (frame_start) begin
            if (frame_cnt == NW'(FLAP_DIV - 1)) begin
                frame_cnt <= '0;
                case (anim_state)
                    ANIM_UP: begin
                        anim_state <= ANIM_MID_A;
                        frame_sel  <= 2'd1;
                    end
                    ANIM_MID_A: begin
                        anim_state <= ANIM_DOWN;
                        frame_sel  <= 2'd2;
                    end
                    ANIM_DOWN: begin
                        anim_state <= ANIM_MID_B;
                        frame_sel  <= 2'd1;
                    end
                    default: begin
                        anim_state <= ANIM_UP;
                        frame_sel  <= 2'd0;
                    end
                endcase
            end else begin
                frame_cnt <= frame_cnt + NW'(1);
            end
        end
    end

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Directed bench for duck_sprite_fetch (SPRITE_W=SPRITE_H=20, FLAP_DIV=2).
module tb_duck_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pixel_valid;
    logic        frame_start;
    logic [9:0]  SpriteX;
    logic [9:0]  SpriteY;
    logic [18:0] ram_addr;
    logic [1:0]  frame_sel;
    logic [4:0]  ram_data;
    logic        pix_valid_out;
    logic        pix_hit;
    logic [4:0]  pix_index;
`ifdef SPRITE_MIRROR_EN
    logic        facing_left;
`endif

    int total = 0;
    int bad   = 0;

    // RAM stub: either a fixed value, or low address bits xor 5'h15
    logic        use_fixed;
    logic [4:0]  fixed_val;

    duck_sprite_fetch #(
        .SPRITE_W(20),
        .SPRITE_H(20),
        .FLAP_DIV(2),
        .TRANSPARENT(5'h00)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .SpriteX(SpriteX),
        .SpriteY(SpriteY),
`ifdef SPRITE_MIRROR_EN
        .facing_left(facing_left),
`endif
        .ram_addr(ram_addr),
        .frame_sel(frame_sel),
        .ram_data(ram_data),
        .pix_valid_out(pix_valid_out),
        .pix_hit(pix_hit),
        .pix_index(pix_index)
    );

    always #5 Clk = ~Clk;

    // Synchronous RAM model: data valid one cycle after ram_addr
    always @(posedge Clk) begin
        ram_data <= use_fixed ? fixed_val : (ram_addr[4:0] ^ 5'h15);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_pix(input int x, input int y, input logic v);
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        pixel_valid = v;
    endtask

    task automatic set_sprite(input int x, input int y);
        SpriteX     = 10'(x);
        SpriteY     = 10'(y);
        frame_start = 1'b1;
        pixel_valid = 1'b0;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive_pix(5, 5, 1'b1);
        step();
        step();
        total++; if (ram_addr !== 19'd0)    begin bad++; $display("FAIL reset_addr got=%0d want=0", ram_addr); end
        total++; if (frame_sel !== 2'd0)    begin bad++; $display("FAIL reset_sel got=%0d want=0", frame_sel); end
        total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL reset_pv got=%0b want=0", pix_valid_out); end
        total++; if (pix_hit !== 1'b0)      begin bad++; $display("FAIL reset_hit got=%0b want=0", pix_hit); end
        total++; if (pix_index !== 5'd0)    begin bad++; $display("FAIL reset_idx got=%0d want=0", pix_index); end
        Reset = 1'b0;
        drive_pix(0, 0, 1'b0);
        step();
    endtask

    task automatic test_basic_hit();
        set_sprite(100, 50);
        use_fixed = 1'b1;
        fixed_val = 5'd7;
        drive_pix(105, 52, 1'b1);
        step();
        total++; if (ram_addr !== 19'd45) begin bad++; $display("FAIL hit_addr got=%0d want=45", ram_addr); end
        drive_pix(0, 0, 1'b0);
        step();
        total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL hit_early_pv got=%0b want=0", pix_valid_out); end
        step();
        total++; if (pix_valid_out !== 1'b1) begin bad++; $display("FAIL hit_pv got=%0b want=1", pix_valid_out); end
        total++; if (pix_hit !== 1'b1)       begin bad++; $display("FAIL hit_hit got=%0b want=1", pix_hit); end
        total++; if (pix_index !== 5'd7)     begin bad++; $display("FAIL hit_idx got=%0d want=7", pix_index); end
        step();
        total++; if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL hit_late_pv got=%0b want=0", pix_valid_out); end
    endtask

    task automatic test_transparent();
        use_fixed = 1'b1;
        fixed_val = 5'd0;
        drive_pix(105, 52, 1'b1);
        step();
        drive_pix(0, 0, 1'b0);
        step();
        step();
        total++; if (pix_valid_out !== 1'b1) begin bad++; $display("FAIL transp_pv got=%0b want=1", pix_valid_out); end
        total++; if (pix_hit !== 1'b0)       begin bad++; $display("FAIL transp_hit got=%0b want=0", pix_hit); end
        total++; if (pix_index !== 5'd0)     begin bad++; $display("FAIL transp_idx got=%0d want=0", pix_index); end
    endtask

    task automatic test_out_of_box();
        use_fixed = 1'b1;
        fixed_val = 5'd7;
        drive_pix(120, 52, 1'b1);
        step();
        total++; if (ram_addr !== 19'd0) begin bad++; $display("FAIL oob_right_addr got=%0d want=0", ram_addr); end
        drive_pix(99, 52, 1'b1);
        step();
        total++; if (ram_addr !== 19'd0) begin bad++; $display("FAIL oob_left_addr got=%0d want=0", ram_addr); end
        drive_pix(0, 0, 1'b0);
        step();
        total++; if (pix_valid_out !== 1'b1 || pix_hit !== 1'b0 || pix_index !== 5'd0)
            begin bad++; $display("FAIL oob_right_out got=pv%0b/hit%0b/idx%0d want=pv1/hit0/idx0", pix_valid_out, pix_hit, pix_index); end
        step();
        total++; if (pix_valid_out !== 1'b1 || pix_hit !== 1'b0 || pix_index !== 5'd0)
            begin bad++; $display("FAIL oob_left_out got=pv%0b/hit%0b/idx%0d want=pv1/hit0/idx0", pix_valid_out, pix_hit, pix_index); end
        use_fixed = 1'b0;
    endtask

    task automatic test_back_to_back();
        int xs [9] = '{99, 100, 119, 120, 100, 100, 101, 105, 105};
        int ys [9] = '{52,  52,  52,  52,  69,  70,  51,  52,  52};
        logic vs [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int ea [9] = '{0, 40, 59, 0, 380, 0, 21, 0, 45};
        logic eh [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int ei [9] = '{0, 29, 14, 0, 9, 0, 0, 0, 24};
        use_fixed = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k < 9) drive_pix(xs[k], ys[k], vs[k]);
            else       drive_pix(0, 0, 1'b0);
            step();
            if (k < 9) begin
                total++;
                if (ram_addr !== 19'(ea[k])) begin bad++; $display("FAIL b2b_addr[%0d] got=%0d want=%0d", k, ram_addr, ea[k]); end
            end
            if (k >= 2) begin
                total++;
                if (pix_valid_out !== vs[k-2] || pix_hit !== eh[k-2] || pix_index !== 5'(ei[k-2])) begin
                    bad++;
                    $display("FAIL b2b_out[%0d] got=pv%0b/hit%0b/idx%0d want=pv%0b/hit%0b/idx%0d",
                             k-2, pix_valid_out, pix_hit, pix_index, vs[k-2], eh[k-2], ei[k-2]);
                end
            end
        end
    endtask

    task automatic test_position_swap();
        SpriteX     = 10'd0;
        SpriteY     = 10'd0;
        frame_start = 1'b1;
        drive_pix(105, 52, 1'b1);
        step();
        frame_start = 1'b0;
        total++; if (ram_addr !== 19'd45) begin bad++; $display("FAIL swap_old_addr got=%0d want=45", ram_addr); end
        drive_pix(5, 2, 1'b1);
        step();
        total++; if (ram_addr !== 19'd45) begin bad++; $display("FAIL swap_new_addr got=%0d want=45", ram_addr); end
        drive_pix(105, 52, 1'b1);
        step();
        total++; if (ram_addr !== 19'd0) begin bad++; $display("FAIL swap_stale_addr got=%0d want=0", ram_addr); end
        drive_pix(0, 0, 1'b0);
        step();
        step();
        step();
    endtask

    task automatic test_wrap();
        set_sprite(1015, 0);
        drive_pix(1023, 0, 1'b1);
        step();
        total++; if (ram_addr !== 19'd8) begin bad++; $display("FAIL wrap_edge_addr got=%0d want=8", ram_addr); end
        drive_pix(2, 0, 1'b1);
        step();
        total++; if (ram_addr !== 19'd0) begin bad++; $display("FAIL wrap_nowrap_addr got=%0d want=0", ram_addr); end
        drive_pix(1014, 0, 1'b1);
        step();
        total++; if (ram_addr !== 19'd0) begin bad++; $display("FAIL wrap_left_addr got=%0d want=0", ram_addr); end
        drive_pix(1015, 19, 1'b1);
        step();
        total++; if (ram_addr !== 19'd380) begin bad++; $display("FAIL wrap_bottom_addr got=%0d want=380", ram_addr); end
        drive_pix(1015, 20, 1'b1);
        step();
        total++; if (ram_addr !== 19'd0) begin bad++; $display("FAIL wrap_below_addr got=%0d want=0", ram_addr); end
        drive_pix(0, 0, 1'b0);
        step();
        step();
        step();
    endtask

    task automatic test_animation();
        logic [1:0] exp_sel [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            set_sprite(10, 10);
            total++;
            if (frame_sel !== exp_sel[i]) begin bad++; $display("FAIL anim_pulse[%0d] got=%0d want=%0d", i, frame_sel, exp_sel[i]); end
            step();
            step();
            total++;
            if (frame_sel !== exp_sel[i]) begin bad++; $display("FAIL anim_hold[%0d] got=%0d want=%0d", i, frame_sel, exp_sel[i]); end
        end
    endtask

    task automatic test_reset_flush();
        set_sprite(10, 10);
        set_sprite(10, 10);
        total++; if (frame_sel !== 2'd1) begin bad++; $display("FAIL flush_pre_sel got=%0d want=1", frame_sel); end
        drive_pix(12, 11, 1'b1);
        step();
        total++; if (ram_addr !== 19'd22) begin bad++; $display("FAIL flush_pre_addr got=%0d want=22", ram_addr); end
        drive_pix(13, 11, 1'b1);
        Reset = 1'b1;
        step();
        total++; if (ram_addr !== 19'd0)     begin bad++; $display("FAIL flush_addr got=%0d want=0", ram_addr); end
        total++; if (frame_sel !== 2'd0)     begin bad++; $display("FAIL flush_sel got=%0d want=0", frame_sel); end
        total++; if (pix_valid_out !== 1'b0 || pix_hit !== 1'b0 || pix_index !== 5'd0)
            begin bad++; $display("FAIL flush_out got=pv%0b/hit%0b/idx%0d want=pv0/hit0/idx0", pix_valid_out, pix_hit, pix_index); end
        Reset = 1'b0;
        drive_pix(0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (pix_valid_out !== 1'b0) begin bad++; $display("FAIL flush_stale_pv[%0d] got=%0b want=0", i, pix_valid_out); end
        end
        drive_pix(3, 1, 1'b1);
        step();
        total++; if (ram_addr !== 19'd23) begin bad++; $display("FAIL flush_post_addr got=%0d want=23", ram_addr); end
        drive_pix(0, 0, 1'b0);
        step();
        step();
        total++; if (pix_valid_out !== 1'b1) begin bad++; $display("FAIL flush_post_pv got=%0b want=1", pix_valid_out); end
    endtask

`ifdef SPRITE_MIRROR_EN
    task automatic test_mirror();
        facing_left = 1'b1;
        set_sprite(100, 50);
        facing_left = 1'b0;
        drive_pix(100, 50, 1'b1);
        step();
        total++; if (ram_addr !== 19'd19) begin bad++; $display("FAIL mirror_corner_addr got=%0d want=19", ram_addr); end
        drive_pix(105, 52, 1'b1);
        step();
        total++; if (ram_addr !== 19'd54) begin bad++; $display("FAIL mirror_mid_addr got=%0d want=54", ram_addr); end
        set_sprite(100, 50);
        drive_pix(100, 50, 1'b1);
        step();
        total++; if (ram_addr !== 19'd0) begin bad++; $display("FAIL mirror_off_addr got=%0d want=0", ram_addr); end
        drive_pix(0, 0, 1'b0);
        step();
        step();
    endtask
`endif

    initial begin
        Reset       = 1'b1;
        DrawX       = '0;
        DrawY       = '0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        SpriteX     = '0;
        SpriteY     = '0;
        use_fixed   = 1'b0;
        fixed_val   = '0;
`ifdef SPRITE_MIRROR_EN
        facing_left = 1'b0;
`endif
        test_reset();
        test_basic_hit();
        test_transparent();
        test_out_of_box();
        test_back_to_back();
        test_position_swap();
        test_wrap();
        test_animation();
        test_reset_flush();
`ifdef SPRITE_MIRROR_EN
        test_mirror();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
